// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : upstream, data-bus and write-back signals of the memory stage
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
    logic        i_valid;
    logic        i_ready;
    logic [3:0]  i_memop;
    logic [31:0] i_ea;
    logic [31:0] i_eb;
    logic [4:0]  i_ern;
    logic        i_wreg;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_result;
    logic [4:0]  o_wrn;
    logic        o_wreg;
    logic        o_adel;
    logic        o_ades;
    logic [31:0] o_badvaddr;

    // master: the memory stage itself
    modport master (
        input  i_valid, i_memop, i_ea, i_eb, i_ern, i_wreg,
        input  data_addr_ok, data_data_ok, data_rdata, o_ready,
        output i_ready, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output o_valid, o_result, o_wrn, o_wreg, o_adel, o_ades, o_badvaddr
    );

    // slave: execute stage, data memory and write-back around it
    modport slave (
        output i_valid, i_memop, i_ea, i_eb, i_ern, i_wreg,
        output data_addr_ok, data_data_ok, data_rdata, o_ready,
        input  i_ready, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  o_valid, o_result, o_wrn, o_wreg, o_adel, o_ades, o_badvaddr
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : MIPS memory-access stage - one bus transaction per instruction,
//             alignment check, store lane steering, load extension
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage (
    input  wire logic   clk,
    input  wire logic   resetn,
    mem_stage_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_op_lb  = 4'd1;
    localparam logic [3:0] c_op_lbu = 4'd2;
    localparam logic [3:0] c_op_lh  = 4'd3;
    localparam logic [3:0] c_op_lhu = 4'd4;
    localparam logic [3:0] c_op_lw  = 4'd5;
    localparam logic [3:0] c_op_sb  = 4'd6;
    localparam logic [3:0] c_op_sh  = 4'd7;
    localparam logic [3:0] c_op_sw  = 4'd8;

    state_t      r_state;
    logic [3:0]  r_memop;
    logic [31:0] r_ea;
    logic [31:0] r_eb;
    logic [4:0]  r_ern;
    logic        r_wreg;
    logic [31:0] r_rdata;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= c_op_lb) && (op <= c_op_lw);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= c_op_sb) && (op <= c_op_sw);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        logic half;
        logic word;
        half = (op == c_op_lh) || (op == c_op_lhu) || (op == c_op_sh);
        word = (op == c_op_lw) || (op == c_op_sw);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

    logic w_accept;
    logic w_in_mem;
    logic w_valid;
    logic w_load;
    logic w_store;
    logic w_mis;

    assign bus.i_ready = resetn && ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.o_ready));
    assign w_accept    = bus.i_valid && bus.i_ready;
    assign w_in_mem    = is_load(bus.i_memop) || is_store(bus.i_memop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_memop <= 4'd0;
            r_ea    <= 32'd0;
            r_eb    <= 32'd0;
            r_ern   <= 5'd0;
            r_wreg  <= 1'b0;
            r_rdata <= 32'd0;
        end else if (w_accept) begin
            r_memop <= bus.i_memop;
            r_ea    <= bus.i_ea;
            r_eb    <= bus.i_eb;
            r_ern   <= bus.i_ern;
            r_wreg  <= bus.i_wreg;
            // Faulting and non-memory ops skip the bus entirely
            r_state <= (w_in_mem && !misaligned(bus.i_memop, bus.i_ea[1:0])) ? S_REQ : S_DONE;
        end else begin
            case (r_state)
                S_REQ:   if (bus.data_addr_ok) r_state <= S_WAIT;
                S_WAIT:  if (bus.data_data_ok) begin
                             r_rdata <= bus.data_rdata;
                             r_state <= S_DONE;
                         end
                S_DONE:  if (bus.o_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_valid = (r_state == S_DONE);
    assign w_load  = is_load(r_memop);
    assign w_store = is_store(r_memop);
    assign w_mis   = misaligned(r_memop, r_ea[1:0]);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ldres;
    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    always_comb begin
        w_byte = r_rdata[7:0];
        case (r_ea[1:0])
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            2'd3:    w_byte = r_rdata[31:24];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = r_ea[1] ? r_rdata[31:16] : r_rdata[15:0];

        w_ldres = r_ea;
        w_size  = 2'd0;
        w_wstrb = 4'd0;
        w_wdata = 32'd0;
        case (r_memop)
            c_op_lb:  w_ldres = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_ldres = {24'd0, w_byte};
            c_op_lh:  begin w_ldres = {{16{w_half[15]}}, w_half}; w_size = 2'd1; end
            c_op_lhu: begin w_ldres = {16'd0, w_half};            w_size = 2'd1; end
            c_op_lw:  begin w_ldres = r_rdata;                    w_size = 2'd2; end
            c_op_sb:  begin
                w_wstrb = 4'b0001 << r_ea[1:0];
                w_wdata = {4{r_eb[7:0]}};
            end
            c_op_sh:  begin
                w_size  = 2'd1;
                w_wstrb = r_ea[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_eb[15:0]}};
            end
            c_op_sw:  begin
                w_size  = 2'd2;
                w_wstrb = 4'b1111;
                w_wdata = r_eb;
            end
            default:  w_ldres = r_ea;
        endcase
    end

    assign bus.data_req   = (r_state == S_REQ);
    assign bus.data_wr    = w_store;
    assign bus.data_size  = w_size;
    assign bus.data_addr  = r_ea;
    assign bus.data_wdata = w_wdata;
    assign bus.data_wstrb = w_wstrb;

    // Exception/writeback qualifiers are masked outside DONE so stale faults never leak
    assign bus.o_valid    = w_valid;
    assign bus.o_result   = (w_load && !w_mis) ? w_ldres : r_ea;
    assign bus.o_wrn      = r_ern;
    assign bus.o_wreg     = w_valid && r_wreg && !w_store && !w_mis;
    assign bus.o_adel     = w_valid && w_mis && w_load;
    assign bus.o_ades     = w_valid && w_mis && w_store;
    assign bus.o_badvaddr = (w_valid && w_mis) ? r_ea : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed and randomized checks of mem_stage against a model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_WAIT = 2;
    localparam int P_DONE = 3;

    logic clk;
    logic resetn;
    mem_stage_if bus ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the instruction currently owned by the stage and where it is
    int          m_phase = P_IDLE;
    logic [3:0]  m_op;
    logic [31:0] m_ea, m_eb, m_rd;
    logic [4:0]  m_ern;
    logic        m_wreg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic op_store(input logic [3:0] op);
        return op >= 4'd6 && op <= 4'd8;
    endfunction

    function automatic logic op_mis(input logic [3:0] op, input logic [31:0] ea);
        int n;
        n = op_bytes(op);
        return n > 1 && (ea % n) != 0;
    endfunction

    function automatic logic [31:0] exp_result();
        int lane;
        logic [31:0] b, h;
        lane = int'(m_ea % 4);
        b = (m_rd >> (8 * lane)) & 32'hFF;
        h = (m_rd >> (16 * (lane / 2))) & 32'hFFFF;
        if (op_mis(m_op, m_ea)) return m_ea;
        case (m_op)
            4'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            4'd2:    return b;
            4'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4'd4:    return h;
            4'd5:    return m_rd;
            default: return m_ea;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata();
        case (m_op)
            4'd6:    return (m_eb & 32'hFF) * 32'h0101_0101;
            4'd7:    return (m_eb & 32'hFFFF) * 32'h0001_0001;
            default: return m_eb;
        endcase
    endfunction

    function automatic logic [3:0] exp_wstrb();
        int lane;
        lane = int'(m_ea % 4);
        case (m_op)
            4'd6:    return 4'(1 << lane);
            4'd7:    return (lane >= 2) ? 4'hC : 4'h3;
            4'd8:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_compare();
        logic mis;
        mis = op_mis(m_op, m_ea);
        chk("i_ready", bus.i_ready, (m_phase == P_IDLE) || (m_phase == P_DONE && bus.o_ready));
        chk("data_req", bus.data_req, m_phase == P_REQ);
        chk("o_valid", bus.o_valid, m_phase == P_DONE);
        if (m_phase == P_REQ) begin
            chk("data_wr", bus.data_wr, op_store(m_op));
            chk("data_size", bus.data_size, op_bytes(m_op) / 2);
            chk("data_addr", bus.data_addr, m_ea);
            chk("data_wstrb", bus.data_wstrb, exp_wstrb());
            if (op_store(m_op)) chk("data_wdata", bus.data_wdata, exp_wdata());
        end
        if (m_phase == P_DONE) begin
            chk("o_result", bus.o_result, exp_result());
            chk("o_wrn", bus.o_wrn, m_ern);
            chk("o_wreg", bus.o_wreg, m_wreg && !op_store(m_op) && !mis);
            chk("o_adel", bus.o_adel, mis && !op_store(m_op));
            chk("o_ades", bus.o_ades, mis && op_store(m_op));
            if (mis) chk("o_badvaddr", bus.o_badvaddr, m_ea);
        end
    endtask

    // Called just after a falling edge: drive inputs, then check the stage
    task automatic drv(input logic v, input logic [3:0] op, input logic [31:0] ea,
                       input logic [31:0] eb, input logic [4:0] ern, input logic wreg,
                       input logic aok, input logic dok, input logic [31:0] rd,
                       input logic ordy);
        bus.i_valid      = v;
        bus.i_memop      = op;
        bus.i_ea         = ea;
        bus.i_eb         = eb;
        bus.i_ern        = ern;
        bus.i_wreg       = wreg;
        bus.data_addr_ok = aok;
        bus.data_data_ok = dok;
        bus.data_rdata   = rd;
        bus.o_ready      = ordy;
        #1;
        model_compare();
    endtask

    task automatic idle(input logic aok, input logic dok, input logic [31:0] rd);
        drv(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, aok, dok, rd, 1'b1);
    endtask

    task automatic adv();
        int nph;
        nph = m_phase;
        if (bus.i_valid && ((m_phase == P_IDLE) || (m_phase == P_DONE && bus.o_ready))) begin
            m_op   = bus.i_memop;
            m_ea   = bus.i_ea;
            m_eb   = bus.i_eb;
            m_ern  = bus.i_ern;
            m_wreg = bus.i_wreg;
            nph = (op_bytes(m_op) > 0 && !op_mis(m_op, m_ea)) ? P_REQ : P_DONE;
        end else if (m_phase == P_REQ && bus.data_addr_ok) begin
            nph = P_WAIT;
        end else if (m_phase == P_WAIT && bus.data_data_ok) begin
            m_rd = bus.data_rdata;
            nph = P_DONE;
        end else if (m_phase == P_DONE && bus.o_ready) begin
            nph = P_IDLE;
        end
        @(posedge clk);
        m_phase = nph;
        @(negedge clk);
    endtask

    initial begin
        resetn           = 1'b0;
        bus.i_valid      = 1'b0;
        bus.i_memop      = 4'd0;
        bus.i_ea         = 32'd0;
        bus.i_eb         = 32'd0;
        bus.i_ern        = 5'd0;
        bus.i_wreg       = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        bus.o_ready      = 1'b1;
        m_op = 4'd0; m_ea = 32'd0; m_eb = 32'd0; m_rd = 32'd0; m_ern = 5'd0; m_wreg = 1'b0;

        #3;
        chk("rst i_ready", bus.i_ready, 0);
        chk("rst data_req", bus.data_req, 0);
        chk("rst o_valid", bus.o_valid, 0);
        chk("rst o_wreg", bus.o_wreg, 0);
        chk("rst o_adel", bus.o_adel, 0);
        chk("rst o_ades", bus.o_ades, 0);
        @(posedge clk); @(negedge clk);
        resetn = 1'b1;

        // Non-memory stream, one result per cycle
        drv(1, 4'd0, 32'h1234, 0, 5'd8, 1, 0, 0, 0, 1); adv();
        drv(1, 4'd0, 32'h1235, 0, 5'd9, 1, 0, 0, 0, 1);
        chk("add result", bus.o_result, 32'h0000_1234);
        chk("add wrn", bus.o_wrn, 8);
        chk("add wreg", bus.o_wreg, 1);
        adv();
        drv(1, 4'd15, 32'h1236, 0, 5'd10, 1, 0, 0, 0, 1);
        chk("stream 2", bus.o_result, 32'h1235);
        adv();
        idle(0, 0, 0);
        chk("stream op15", bus.o_result, 32'h1236);
        adv();

        // LB with stalled handshakes, then the same access as LBU
        for (int k = 0; k < 2; k++) begin
            drv(1, (k == 0) ? 4'd1 : 4'd2, 32'h8000_0003, 32'hFFFF_FFFF, 5'd4, 1, 0, 0, 0, 1); adv();
            for (int s = 0; s < 2; s++) begin
                idle(0, 1, 32'hFFFF_FFFF);
                chk("lb req held", bus.data_req, 1);
                chk("lb size", bus.data_size, 0);
                chk("lb wstrb", bus.data_wstrb, 0);
                adv();
            end
            idle(1, 0, 0); adv();
            idle(1, 0, 0); adv();
            idle(0, 0, 32'h1234_5678); adv();
            idle(0, 1, 32'h80FF_0000); adv();
            idle(0, 0, 0);
            chk(k == 0 ? "lb result" : "lbu result", bus.o_result,
                k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
            adv();
        end

        // SH steering
        drv(1, 4'd7, 32'h1002, 32'hDEAD_BEEF, 5'd2, 1, 0, 0, 0, 1); adv();
        idle(1, 0, 0);
        chk("sh wstrb", bus.data_wstrb, 4'b1100);
        chk("sh wdata", bus.data_wdata, 32'hBEEF_BEEF);
        chk("sh wr", bus.data_wr, 1);
        adv();
        idle(0, 1, 0); adv();
        idle(0, 0, 0);
        chk("sh wreg", bus.o_wreg, 0);
        adv();

        // Misaligned LW and SW
        drv(1, 4'd5, 32'h1001, 0, 5'd3, 1, 1, 1, 0, 1); adv();
        idle(0, 0, 0);
        chk("lw adel", bus.o_adel, 1);
        chk("lw badvaddr", bus.o_badvaddr, 32'h1001);
        chk("lw wreg", bus.o_wreg, 0);
        adv();
        drv(1, 4'd8, 32'h1002, 0, 5'd3, 1, 1, 1, 0, 1); adv();
        idle(0, 0, 0);
        chk("sw ades", bus.o_ades, 1);
        adv();

        // Write-back backpressure, then capture on the releasing edge
        drv(1, 4'd0, 32'h55, 0, 5'd3, 1, 0, 0, 0, 0); adv();
        for (int s = 0; s < 4; s++) begin
            drv(1, 4'd0, 32'h66, 0, 5'd4, 1, 0, 0, 0, 0);
            chk("bp i_ready", bus.i_ready, 0);
            chk("bp result", bus.o_result, 32'h55);
            adv();
        end
        drv(1, 4'd0, 32'h66, 0, 5'd4, 1, 0, 0, 0, 1);
        chk("bp release", bus.i_ready, 1);
        adv();
        idle(0, 0, 0);
        chk("bp next", bus.o_result, 32'h66);
        adv();

        // Reset while waiting for data
        drv(1, 4'd5, 32'h2000, 0, 5'd5, 1, 1, 0, 0, 1); adv();
        idle(1, 0, 0); adv();
        idle(0, 0, 0);
        #2 resetn = 1'b0;
        #1;
        chk("mid rst data_req", bus.data_req, 0);
        chk("mid rst o_valid", bus.o_valid, 0);
        chk("mid rst adel", bus.o_adel | bus.o_ades, 0);
        m_phase = P_IDLE;
        @(posedge clk); @(negedge clk);
        resetn = 1'b1;
        idle(0, 1, 0);
        chk("post rst i_ready", bus.i_ready, 1);
        adv();

        // Randomized traffic with random bus latency and write-back stalls
        for (int c = 0; c < 3000; c++) begin
            drv(($urandom % 10) < 6, 4'($urandom), $urandom, $urandom, 5'($urandom),
                1'($urandom), ($urandom % 2) == 0, ($urandom % 3) == 0, $urandom,
                ($urandom % 10) < 7);
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
